// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, frame width and the
// even-parity helper used by both the receive and transmit sides.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Even parity: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sequencer_if.sv
// Host-side bus of the UART receiver: held frame, error flags, busy and
// the FSM state for observation.
// Handshake: a frame transfers on every rising clk edge where rx_valid and
// rx_ready are both high; rx_valid with its data and flags stays stable
// until that transfer, and rx_ready may toggle freely.
interface uart_rx_sequencer_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_error;
  logic                 stop_error;
  logic                 overrun_error;
  logic                 rx_busy;
  rx_state_e            state;

  modport master (
    output rx_data_out, rx_valid, parity_error, stop_error,
           overrun_error, rx_busy, state,
    input  rx_ready
  );

  modport slave (
    input  rx_data_out, rx_valid, parity_error, stop_error,
           overrun_error, rx_busy, state,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus falling-edge
// detector. Every flop resets to the line-idle level so reset never
// fabricates a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rxs_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  // Synchronizer chain and one-cycle history of the synchronized line.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rxs_o  = s2_q;
  assign fall_o = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// Counter-timed UART receive FSM with valid/ready output and overrun flag.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and
// the PARITY state; without it parity_error is constant 0.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data_in,
  uart_rx_sequencer_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // Counter restarts at 0 after each sample, so limits are interval-1.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic rxs, fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx_data_in),
    .rxs_o  (rxs),
    .fall_o (fall)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tick, load, frame_perr;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 se_q, se_d;
  logic                 ov_q, ov_d;
  logic                 xfer;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  assign frame_perr = perr_q;
`else
  assign frame_perr = 1'b0;
`endif

  // START samples half a bit after the edge; later states a full bit apart.
  assign tick = (cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1));

  // FSM state and bit-timing datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic: sample on tick, otherwise keep counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    idx_d   = idx_q;
    sh_d    = sh_q;
    load    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = even_parity(sh_q) ^ rxs;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d   = '0;
          load    = 1'b1;
          state_d = rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    bus.rx_busy = (state_q != IDLE);
    bus.state   = state_q;
  end

  // Output holding register: load, transfer and overrun resolution.
  always_comb begin
    xfer    = valid_q & bus.rx_ready;
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    se_d    = se_q;
    ov_d    = ov_q;
    if (xfer) begin
      valid_d = 1'b0;
      ov_d    = 1'b0;
    end
    if (load) begin
      if (valid_q && !xfer) begin
        ov_d = 1'b1;
      end else begin
        data_d  = sh_q;
        pe_d    = frame_perr;
        se_d    = ~rxs;
        valid_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      se_q    <= se_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.rx_data_out   = data_q;
  assign bus.rx_valid      = valid_q;
  assign bus.parity_error  = pe_q;
  assign bus.stop_error    = se_q;
  assign bus.overrun_error = ov_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer (CLKS_PER_BIT=16); adapts frame
// format and latency to UART_RX_PARITY_EN.
module tb_uart_rx_sequencer;
  import uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
  localparam logic PE_EN = 1'b1;
`else
  localparam int NB = 9;
  localparam logic PE_EN = 1'b0;
`endif
  localparam int LAT = 2 + CPB / 2 + NB * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int   cyc = 0;

  uart_rx_sequencer_if bus ();

  uart_rx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_in (rx),
    .bus        (bus)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  int start_cyc = 0;

  // Monitor (negedge): transfers, valid rises, valid/busy occupancy
  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  int rise_cyc = 0, rise_cnt = 0, vhigh_cnt = 0, busy_cnt = 0;
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid && bus.rx_ready)
        got.push_back({bus.stop_error, bus.parity_error, bus.rx_data_out});
      if (bus.rx_valid && !prev_v) begin
        rise_cyc = cyc;
        rise_cnt++;
      end
      if (bus.rx_valid) vhigh_cnt++;
      if (bus.rx_busy)  busy_cnt++;
      prev_v = bus.rx_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one frame, each bit held CPB cycles; returns with stop bit on line.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] bits;
    int nbits;
`ifdef UART_RX_PARITY_EN
    bits = {stp, par, d, 1'b0};
    nbits = 11;
`else
    bits = {par, stp, d, 1'b0};
    nbits = 10;
`endif
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: delivered frames vs expected queue.
  task automatic sb_check(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    while (got.size() > 0 && exp_q.size() > 0)
      check({tag, "_frame"}, got.pop_front(), exp_q.pop_front());
    got.delete();
    exp_q.delete();
  endtask

  int base_v, base_b, base_r;

  initial begin
    bus.rx_ready = 1'b0;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_data", bus.rx_data_out, 8'h00);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_perr", bus.parity_error, 1'b0);
    check("rst_serr", bus.stop_error, 1'b0);
    check("rst_ovr", bus.overrun_error, 1'b0);
    check("rst_busy", bus.rx_busy, 1'b0);
    rst = 1'b0;
    idle(5);

    // 0xA5, consumer always ready: latency and one-cycle pulse
    bus.rx_ready = 1'b1;
    base_v = vhigh_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    check("a5_latency", rise_cyc - start_cyc, LAT);
    check("a5_pulse", vhigh_cnt - base_v, 1);
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    sb_check("a5");

    // 6-cycle glitch: false start
    base_b = busy_cnt;
    base_r = rise_cnt;
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    idle(20);
    check("glitch_busy", busy_cnt - base_b, 8);
    check("glitch_novalid", rise_cnt - base_r, 0);
    check("glitch_state", 32'(bus.state), 32'(IDLE));

    // Parity error frame, then stop-bit error with break
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(20);
    exp_q.push_back({1'b0, PE_EN, 8'h3C});
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("brk_state", 32'(bus.state), 32'(BREAK));
    check("brk_busy", bus.rx_busy, 1'b1);
    idle(6);
    check("brk_exit_busy", bus.rx_busy, 1'b0);
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    idle(10);
    sb_check("err");

    // Back-to-back with consumer stalled: overrun
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(20);
    check("ovr_valid", bus.rx_valid, 1'b1);
    check("ovr_data", bus.rx_data_out, 8'h11);
    check("ovr_flag", bus.overrun_error, 1'b1);
    bus.rx_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    @(posedge clk); #1;
    check("ovr_clr_valid", bus.rx_valid, 1'b0);
    check("ovr_clr_flag", bus.overrun_error, 1'b0);
    idle(5);
    sb_check("ovr");

    // Simultaneous load and transfer
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    idle(20);
    check("sim_pending", bus.rx_valid, 1'b1);
    fork
      send_frame(8'h55, 1'b0, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
      end
    join
    idle(5);
    check("sim_valid", bus.rx_valid, 1'b1);
    check("sim_data", bus.rx_data_out, 8'h55);
    check("sim_ovr", bus.overrun_error, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    exp_q.push_back({1'b0, 1'b0, 8'h55});
    bus.rx_ready = 1'b1;
    idle(3);
    sb_check("sim");

    // Reset during data bit 4 with a frame still pending
    bus.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(20);
    check("mid_pending", bus.rx_valid, 1'b1);
    fork
      send_frame(8'hF8, 1'b1, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (85) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_valid", bus.rx_valid, 1'b0);
        check("mid_data", bus.rx_data_out, 8'h00);
        check("mid_busy", bus.rx_busy, 1'b0);
        check("mid_state", 32'(bus.state), 32'(IDLE));
        check("mid_flags", {bus.parity_error, bus.stop_error, bus.overrun_error}, 3'b000);
      end
    join
    idle(10);
    check("mid_idle", bus.rx_busy, 1'b0);
    bus.rx_ready = 1'b1;
    send_frame(8'h7E, 1'b0, 1'b1);
    idle(20);
    check("post_rst_latency", rise_cyc - start_cyc, LAT);
    exp_q.push_back({1'b0, 1'b0, 8'h7E});
    sb_check("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
